// File: rtl/cgra_col_obi_arbiter_pkg.sv
// Shared CGRA/X-HEEP constants and types for the column-to-bus OBI arbiter.
// The external crossbar master count and its index width are fixed here for the whole CGRA top.
package cgra_col_obi_arbiter_pkg;

    localparam int unsigned EXT_XBAR_NMASTER     = 4;
    localparam int unsigned LOG_EXT_XBAR_NMASTER = (EXT_XBAR_NMASTER > 1) ? $clog2(EXT_XBAR_NMASTER) : 1;
    localparam int unsigned CGRA_ARB_MAX_OUTST   = 2;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_BE_W   = 4;

    typedef struct packed {
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_ADDR_W-1:0] addr;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_addr_phase_t;

    // Index width that stays at least one bit for a single-entry range.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cgra_col_obi_arbiter_id_fifo.sv
// In-order FIFO of winner column indices, one entry per accepted bus request.
// Pointers wrap modulo DEPTH; count is exposed so the arbiter can report outstanding transactions.
module cgra_arb_id_fifo
    import cgra_col_obi_arbiter_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 2,
    localparam int unsigned PTR_W = idx_width(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/cgra_col_obi_arbiter.sv
// Round-robin arbiter merging the CGRA column OBI masters onto one OBI bus port.
// Responses are steered back in order through an ID FIFO with a zero-latency rvalid path.
module cgra_col_obi_arbiter
    import cgra_col_obi_arbiter_pkg::*;
#(
    parameter  int unsigned N_MASTER  = EXT_XBAR_NMASTER,
    parameter  int unsigned MAX_OUTST = CGRA_ARB_MAX_OUTST,
    localparam int unsigned OUTST_W   = $clog2(MAX_OUTST) + 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,

    input  logic [N_MASTER-1:0]              col_req_i,
    input  logic [N_MASTER-1:0]              col_we_i,
    input  logic [N_MASTER*OBI_BE_W-1:0]     col_be_i,
    input  logic [N_MASTER*OBI_ADDR_W-1:0]   col_addr_i,
    input  logic [N_MASTER*OBI_DATA_W-1:0]   col_wdata_i,
    output logic [N_MASTER-1:0]              col_gnt_o,
    output logic [N_MASTER-1:0]              col_rvalid_o,
    output logic [N_MASTER*OBI_DATA_W-1:0]   col_rdata_o,

    output logic                             bus_req_o,
    output logic                             bus_we_o,
    output logic [OBI_BE_W-1:0]              bus_be_o,
    output logic [OBI_ADDR_W-1:0]            bus_addr_o,
    output logic [OBI_DATA_W-1:0]            bus_wdata_o,
    input  logic                             bus_gnt_i,
    input  logic                             bus_rvalid_i,
    input  logic [OBI_DATA_W-1:0]            bus_rdata_i,

    output logic                             busy_o,
    output logic [OUTST_W-1:0]               outst_o
);

    localparam int unsigned IDX_W = (N_MASTER == EXT_XBAR_NMASTER) ? LOG_EXT_XBAR_NMASTER
                                                                   : idx_width(N_MASTER);
    typedef logic [IDX_W-1:0] idx_t;

    idx_t            rr_ptr;
    idx_t            rr_winner;
    idx_t            cand;
    idx_t            winner;
    idx_t            lock_idx;
    idx_t            head_idx;
    logic            rr_found;
    logic            lock;
    logic            any_req;
    logic            handshake;
    logic            rsp_ok;
    logic            fifo_full;
    logic            fifo_empty;
    obi_addr_phase_t sel;

    // First requester at or after the pointer, scanning upward with wrap.
    always_comb begin
        rr_winner = rr_ptr;
        rr_found  = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < N_MASTER; k++) begin
            cand = idx_t'((32'(rr_ptr) + k) % N_MASTER);
            if (!rr_found && col_req_i[cand]) begin
                rr_found  = 1'b1;
                rr_winner = cand;
            end
        end
    end

    // A request left waiting for gnt keeps its column so the address phase cannot change.
    assign winner = (lock && col_req_i[lock_idx]) ? lock_idx : rr_winner;

    always_comb begin
        sel = '0;
        for (int unsigned k = 0; k < N_MASTER; k++) begin
            if (idx_t'(k) == winner) begin
                sel.we    = col_we_i[k];
                sel.be    = col_be_i[k*OBI_BE_W +: OBI_BE_W];
                sel.addr  = col_addr_i[k*OBI_ADDR_W +: OBI_ADDR_W];
                sel.wdata = col_wdata_i[k*OBI_DATA_W +: OBI_DATA_W];
            end
        end
    end

    assign any_req     = |col_req_i;
    // Gated by the registered count only, so a same-cycle rvalid never frees a slot.
    assign bus_req_o   = any_req && !fifo_full && !rst_i;
    assign bus_we_o    = sel.we;
    assign bus_be_o    = sel.be;
    assign bus_addr_o  = sel.addr;
    assign bus_wdata_o = sel.wdata;

    assign handshake = bus_req_o && bus_gnt_i;
    assign rsp_ok    = bus_rvalid_i && !fifo_empty;

    always_comb begin
        col_gnt_o    = '0;
        col_rvalid_o = '0;
        for (int unsigned k = 0; k < N_MASTER; k++) begin
            col_gnt_o[k]    = handshake && (idx_t'(k) == winner);
            col_rvalid_o[k] = rsp_ok && (idx_t'(k) == head_idx);
        end
    end

    assign col_rdata_o = {N_MASTER{bus_rdata_i}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else begin
            lock     <= bus_req_o && !bus_gnt_i;
            lock_idx <= winner;
            if (handshake) begin
                rr_ptr <= (winner == idx_t'(N_MASTER - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

    cgra_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (handshake),
        .push_data (winner),
        .pop       (rsp_ok),
        .head      (head_idx),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outst_o)
    );

    assign busy_o = (outst_o != '0);

`ifndef SYNTHESIS
    // Simulation-only flag for a response arriving with nothing outstanding; it is dropped.
    stray_rvalid: assert property (@(posedge clk_i) disable iff (rst_i) bus_rvalid_i |-> !fifo_empty)
        else $warning("bus_rvalid_i with no outstanding transaction, response dropped");
`endif

endmodule

// File: tb/tb_cgra_col_obi_arbiter.sv
// Scoreboard bench for cgra_col_obi_arbiter: grants push the expected response column,
// bus responses pop it and check routing of rvalid/rdata.
module tb_cgra_col_obi_arbiter;
    import cgra_col_obi_arbiter_pkg::*;

    localparam int NM = EXT_XBAR_NMASTER;
    localparam int MO = CGRA_ARB_MAX_OUTST;
    localparam int OW = $clog2(MO) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [NM-1:0]   col_req;
    logic [NM-1:0]   col_we;
    logic [NM*4-1:0] col_be;
    logic [NM*32-1:0] col_addr;
    logic [NM*32-1:0] col_wdata;
    logic [NM-1:0]   col_gnt;
    logic [NM-1:0]   col_rvalid;
    logic [NM*32-1:0] col_rdata;
    logic            bus_req;
    logic            bus_we;
    logic [3:0]      bus_be;
    logic [31:0]     bus_addr;
    logic [31:0]     bus_wdata;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [31:0]     bus_rdata;
    logic            busy;
    logic [OW-1:0]   outst;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    cgra_col_obi_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .col_req_i    (col_req),
        .col_we_i     (col_we),
        .col_be_i     (col_be),
        .col_addr_i   (col_addr),
        .col_wdata_i  (col_wdata),
        .col_gnt_o    (col_gnt),
        .col_rvalid_o (col_rvalid),
        .col_rdata_o  (col_rdata),
        .bus_req_o    (bus_req),
        .bus_we_o     (bus_we),
        .bus_be_o     (bus_be),
        .bus_addr_o   (bus_addr),
        .bus_wdata_o  (bus_wdata),
        .bus_gnt_i    (bus_gnt),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata),
        .busy_o       (busy),
        .outst_o      (outst)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at posedge+1, sample at posedge+4. exp_win < 0 means no grant expected.
    task automatic cycle(input string tag, input logic [NM-1:0] req, input logic gnt,
                         input logic rvalid, input logic [31:0] rdata, input int exp_win);
        logic [NM-1:0]    exp_vec;
        logic [NM*32-1:0] wide;
        logic [NM*4-1:0]  wide_be;
        int               head;
        @(posedge clk);
        #1;
        col_req    = req;
        bus_gnt    = gnt;
        bus_rvalid = rvalid;
        bus_rdata  = rdata;
        #3;
        exp_vec = (exp_win >= 0) ? (NM'(1) << exp_win) : '0;
        check({tag, ".gnt"}, 64'(col_gnt), 64'(exp_vec));
        if (exp_win >= 0) begin
            wide = col_addr >> (32 * exp_win);
            check({tag, ".addr"}, 64'(bus_addr), 64'(wide[31:0]));
            wide = col_wdata >> (32 * exp_win);
            check({tag, ".wdata"}, 64'(bus_wdata), 64'(wide[31:0]));
            wide_be = col_be >> (4 * exp_win);
            check({tag, ".be"}, 64'(bus_be), 64'(wide_be[3:0]));
            exp_vec = col_we >> exp_win;
            check({tag, ".we"}, 64'(bus_we), 64'(exp_vec[0]));
        end
        exp_vec = '0;
        if (rvalid && exp_q.size() > 0) begin
            head    = exp_q.pop_front();
            exp_vec = NM'(1) << head;
            wide    = col_rdata >> (32 * head);
            check({tag, ".rdata"}, 64'(wide[31:0]), 64'(rdata));
        end
        check({tag, ".rvalid"}, 64'(col_rvalid), 64'(exp_vec));
        if (exp_win >= 0) exp_q.push_back(exp_win);
    endtask

    task automatic idle_check(input string tag, input int exp_outst);
        cycle({tag, ".idle"}, '0, 1'b0, 1'b0, 32'h0, -1);
        check({tag, ".outst"}, 64'(outst), 64'(exp_outst));
        check({tag, ".busy"}, 64'(busy), 64'(exp_outst != 0));
    endtask

    initial begin
        col_addr  = {32'h0000_0D00, 32'h0000_0100, 32'h0000_0B00, 32'h0000_0A00};
        col_wdata = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
        col_be    = {4'hC, 4'hF, 4'h3, 4'h1};
        col_we    = 4'b1010;

        // Reset with every column requesting: nothing may leak out.
        rst        = 1'b1;
        col_req    = '1;
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h5555_5555;
        repeat (2) @(posedge clk);
        #4;
        check("rst.bus_req", 64'(bus_req), 64'h0);
        check("rst.gnt", 64'(col_gnt), 64'h0);
        check("rst.rvalid", 64'(col_rvalid), 64'h0);
        check("rst.busy", 64'(busy), 64'h0);
        check("rst.outst", 64'(outst), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; col_req = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0;

        // All columns request: 0 then 1 granted, third stalls at the outstanding limit.
        cycle("rr0", 4'hF, 1'b1, 1'b0, 32'h0, 0);
        cycle("rr1", 4'hF, 1'b1, 1'b0, 32'h0, 1);
        cycle("rr_stall", 4'hF, 1'b1, 1'b1, 32'h1111_0000, -1);
        check("rr_stall.bus_req", 64'(bus_req), 64'h0);
        cycle("rr2", 4'hF, 1'b1, 1'b1, 32'h1111_0001, 2);
        check("rr2.bus_req", 64'(bus_req), 64'h1);
        cycle("rr3", 4'hF, 1'b1, 1'b0, 32'h0, 3);
        check("push_pop.outst", 64'(outst), 64'h1);
        cycle("rr_rsp2", 4'h0, 1'b1, 1'b1, 32'h1111_0002, -1);
        cycle("rr_rsp3", 4'h0, 1'b1, 1'b1, 32'h1111_0003, -1);
        idle_check("rr", 0);

        // Column 2 read with gnt held off three cycles; column 1 joins but must not steal the slot.
        cycle("hold0", 4'b0100, 1'b0, 1'b0, 32'h0, -1);
        check("hold0.addr", 64'(bus_addr), 64'h100);
        check("hold0.bus_req", 64'(bus_req), 64'h1);
        cycle("hold1", 4'b0110, 1'b0, 1'b0, 32'h0, -1);
        check("hold1.addr", 64'(bus_addr), 64'h100);
        cycle("hold2", 4'b0110, 1'b0, 1'b0, 32'h0, -1);
        check("hold2.addr", 64'(bus_addr), 64'h100);
        cycle("hold3", 4'b0110, 1'b1, 1'b0, 32'h0, 2);
        check("hold3.addr", 64'(bus_addr), 64'h100);
        cycle("hold_rsp", 4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF, -1);
        idle_check("hold", 0);

        // Column 1 then column 3, responses return in that order.
        cycle("ord1", 4'b0010, 1'b1, 1'b0, 32'h0, 1);
        cycle("ord3", 4'b1000, 1'b1, 1'b0, 32'h0, 3);
        cycle("ord_rsp1", 4'b0000, 1'b0, 1'b1, 32'h2222_0001, -1);
        cycle("ord_rsp3", 4'b0000, 1'b0, 1'b1, 32'h2222_0003, -1);
        idle_check("ord", 0);

        // Reset with two outstanding, then a stray response.
        cycle("pre_rst0", 4'b0001, 1'b1, 1'b0, 32'h0, 0);
        cycle("pre_rst1", 4'b0001, 1'b1, 1'b0, 32'h0, 0);
        idle_check("pre_rst", 2);
        @(posedge clk);
        #1;
        rst = 1'b1; col_req = '1; bus_gnt = 1'b1; bus_rvalid = 1'b1;
        #3;
        check("mid_rst.bus_req", 64'(bus_req), 64'h0);
        check("mid_rst.gnt", 64'(col_gnt), 64'h0);
        check("mid_rst.rvalid", 64'(col_rvalid), 64'h0);
        check("mid_rst.busy", 64'(busy), 64'h0);
        check("mid_rst.outst", 64'(outst), 64'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0; col_req = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        cycle("stray", 4'b0000, 1'b0, 1'b1, 32'h3333_3333, -1);
        idle_check("stray", 0);

        // Lone column 3 is granted every cycle the bus grants.
        cycle("solo0", 4'b1000, 1'b1, 1'b0, 32'h0, 3);
        for (int i = 1; i < 6; i++) begin
            cycle("solo", 4'b1000, 1'b1, 1'b1, 32'h4444_0000 + 32'(i), 3);
            check("solo.bus_req", 64'(bus_req), 64'h1);
        end
        cycle("solo_rsp", 4'b0000, 1'b0, 1'b1, 32'h4444_00FF, -1);
        idle_check("solo", 0);
        check("scoreboard.empty", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
